// File: rtl/nubus_slot_bridge.sv
// CPU-side bridge for one NuBus slot: turns 68000 AS/UDS/LDS cycles into the card's
// select/ack_n handshake, with a bus-error timeout and an nmrq_n synchroniser.
module nubus_slot_bridge #(
   parameter logic [3:0] SLOT_ID        = 4'h9,
   parameter int         TIMEOUT_CYCLES = 255,
   parameter bit         SUPER_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   input  logic        cpu_as_n,
   input  logic        cpu_uds_n,
   input  logic        cpu_lds_n,
   input  logic        cpu_rw_n,
   output logic        cpu_dtack_n,
   output logic        cpu_berr_n,
   output logic        slot_hit,
   output logic [31:0] card_addr,
   output logic [15:0] card_dout,
   input  logic [15:0] card_din,
   output logic [1:0]  card_uds_lds,
   output logic        card_rw_n,
   output logic        card_select,
   input  logic        card_ack_n,
   input  logic        card_nmrq_n,
   output logic        slot_irq_n
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_HOLD, S_RECOVER} state_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        dtack_n_q, dtack_n_d;
   logic        berr_n_q, berr_n_d;
   logic        select_q, select_d;
   logic        rw_n_q, rw_n_d;
   logic [1:0]  ul_q, ul_d;
   logic [15:0] dout_q, dout_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic        sync1_q, sync2_q;

   logic        std_hit, super_hit, strobe;
   logic [31:0] dec_addr;

   // Standard space wins if both decodes could match (only when SLOT_ID is F).
   always_comb begin
      std_hit     = (cpu_addr[31:24] == {4'hF, SLOT_ID});
      super_hit   = SUPER_EN && (cpu_addr[31:28] == SLOT_ID);
      dec_addr    = std_hit ? {8'h00, cpu_addr[23:0]} : {4'h0, cpu_addr[27:0]};
      dec_addr[0] = 1'b0;
   end

   assign slot_hit = std_hit | super_hit;
   assign strobe   = ~cpu_uds_n | ~cpu_lds_n;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      select_d  = select_q;
      rw_n_d    = rw_n_q;
      ul_d      = ul_q;
      dout_d    = dout_q;
      wdata_d   = wdata_q;
      addr_d    = addr_q;
      case (state_q)
         S_IDLE: begin
            if (!cpu_as_n && slot_hit && strobe && card_ack_n) begin
               addr_d   = dec_addr;
               wdata_d  = cpu_din;
               ul_d     = {~cpu_uds_n, ~cpu_lds_n};
               rw_n_d   = cpu_rw_n;
               select_d = 1'b1;
               cnt_d    = 8'd0;
               state_d  = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            // An abandoned CPU cycle takes priority over a simultaneous ack.
            if (cpu_as_n) begin
               select_d = 1'b0;
               cnt_d    = 8'd0;
               state_d  = S_RECOVER;
            end else if (!card_ack_n) begin
               if (rw_n_q) dout_d = card_din;
               dtack_n_d = 1'b0;
               state_d   = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               berr_n_d = 1'b0;
               select_d = 1'b0;
               state_d  = S_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (cpu_as_n) begin
               dtack_n_d = 1'b1;
               berr_n_d  = 1'b1;
               select_d  = 1'b0;
               cnt_d     = 8'd0;
               state_d   = S_RECOVER;
            end
         end
         S_RECOVER: begin
            // One cycle of dwell keeps at least 3 clk between AS release and the next select.
            if (cnt_q == 8'd0) begin
               cnt_d = 8'd1;
            end else if (card_ack_n) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         select_q  <= 1'b0;
         rw_n_q    <= 1'b1;
         ul_q      <= 2'b00;
         dout_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         addr_q    <= 32'h0000_0000;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         select_q  <= select_d;
         rw_n_q    <= rw_n_d;
         ul_q      <= ul_d;
         dout_q    <= dout_d;
         wdata_q   <= wdata_d;
         addr_q    <= addr_d;
         sync1_q   <= card_nmrq_n;
         sync2_q   <= sync1_q;
      end
   end

   assign cpu_dout     = dout_q;
   assign cpu_dtack_n  = dtack_n_q;
   assign cpu_berr_n   = berr_n_q;
   assign card_addr    = addr_q;
   assign card_dout    = wdata_q;
   assign card_uds_lds = ul_q;
   assign card_rw_n    = rw_n_q;
   assign card_select  = select_q;
   assign slot_irq_n   = sync2_q;

endmodule

// File: tb/tb_nubus_slot_bridge.sv
// Bench for nubus_slot_bridge: vector table, hand-written corner sequences and
// random CPU cycles scored against a transaction-level model.
module tb_nubus_slot_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [15:0] cpu_din;
   logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw_n;
   logic [15:0] card_din;
   logic        card_ack_n, card_nmrq_n;

   logic [15:0] cpu_dout, cpu_dout0;
   logic        cpu_dtack_n, cpu_berr_n, slot_hit;
   logic [31:0] card_addr;
   logic [15:0] card_dout;
   logic [1:0]  card_uds_lds;
   logic        card_rw_n, card_select, slot_irq_n;
   logic        cpu_dtack_n0, cpu_berr_n0, slot_hit0;
   logic [31:0] card_addr0;
   logic [15:0] card_dout0;
   logic [1:0]  card_uds_lds0;
   logic        card_rw_n0, card_select0, slot_irq_n0;

   always #5 clk = ~clk;

   nubus_slot_bridge dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw_n(cpu_rw_n),
      .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .slot_hit(slot_hit),
      .card_addr(card_addr), .card_dout(card_dout), .card_din(card_din),
      .card_uds_lds(card_uds_lds), .card_rw_n(card_rw_n), .card_select(card_select),
      .card_ack_n(card_ack_n), .card_nmrq_n(card_nmrq_n), .slot_irq_n(slot_irq_n));

   nubus_slot_bridge #(.SUPER_EN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout0),
      .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw_n(cpu_rw_n),
      .cpu_dtack_n(cpu_dtack_n0), .cpu_berr_n(cpu_berr_n0), .slot_hit(slot_hit0),
      .card_addr(card_addr0), .card_dout(card_dout0), .card_din(card_din),
      .card_uds_lds(card_uds_lds0), .card_rw_n(card_rw_n0), .card_select(card_select0),
      .card_ack_n(card_ack_n), .card_nmrq_n(card_nmrq_n), .slot_irq_n(slot_irq_n0));

   typedef struct {
      logic [31:0] addr;  logic [15:0] din;  logic u, l, rw;  int ad;  logic [15:0] cd;
      logic ehit, esel;   logic [31:0] ecaddr;  logic [15:0] ecdout;  logic [1:0] eul;
      logic erw, eberr;   logic [15:0] edout;
   } vec_t;

   typedef struct {
      logic hit;  int sel, ack, dtk, berr;  logic [31:0] caddr;  logic [15:0] cdout, dout;
      logic [1:0] ul;  logic rw, both, rel, selend;
   } res_t;

   int total = 0, bad = 0;
   // Card responder state: acks ad cycles after it registers select, releases one cycle after select drops.
   bit          card_auto = 1'b1;
   int          ackd = 0, ack_cnt = 0;
   logic        sel_prev = 1'b0;
   logic [15:0] model_dout = 16'h0000;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      if (card_auto) begin
         if (sel_prev && ackd >= 0) begin
            if (ack_cnt == ackd) card_ack_n = 1'b0;
            else ack_cnt++;
         end else if (!sel_prev) begin
            card_ack_n = 1'b1;
            ack_cnt = 0;
         end
      end
      sel_prev = card_select;
   endtask

   task automatic run_cycle(input logic [31:0] a, input logic [15:0] d, input logic u, l, rw,
                            input int ad, input logic [15:0] cd, output res_t r);
      r.sel = -1; r.ack = -1; r.dtk = -1; r.berr = -1; r.both = 1'b0;
      cpu_addr = a; cpu_din = d; cpu_uds_n = u; cpu_lds_n = l; cpu_rw_n = rw;
      ackd = ad; card_din = cd; cpu_as_n = 1'b0;
      #1 r.hit = slot_hit;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (card_select && r.sel < 0) r.sel = k;
         if (!card_ack_n && r.ack < 0) r.ack = k;
         if (!cpu_dtack_n && r.dtk < 0) r.dtk = k;
         if (!cpu_berr_n && r.berr < 0) r.berr = k;
         if (!cpu_dtack_n && !cpu_berr_n) r.both = 1'b1;
         if (r.dtk >= 0 || r.berr >= 0 || (r.sel < 0 && k >= 4)) break;
      end
      r.selend = card_select;
      r.caddr = card_addr; r.cdout = card_dout; r.ul = card_uds_lds; r.rw = card_rw_n;
      r.dout = cpu_dout;
      cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
      tick();
      r.rel = cpu_dtack_n && cpu_berr_n && !card_select;
      repeat (5) tick();
   endtask

   task automatic score(input string tag, input vec_t v, input res_t r);
      chk({tag, "_hit"}, r.hit, v.ehit);
      chk({tag, "_sel_lat"}, r.sel, v.esel ? 1 : -1);
      chk({tag, "_card_addr"}, r.caddr, v.ecaddr);
      chk({tag, "_card_dout"}, r.cdout, v.ecdout);
      chk({tag, "_uds_lds"}, r.ul, v.eul);
      chk({tag, "_rw"}, r.rw, v.erw);
      chk({tag, "_cpu_dout"}, r.dout, v.edout);
      chk({tag, "_berr"}, r.berr >= 0, v.eberr);
      if (v.esel && v.eberr) begin
         chk({tag, "_berr_lat"}, r.berr - r.sel, 255);
         chk({tag, "_no_dtack"}, r.dtk, -1);
         chk({tag, "_sel_drop"}, r.selend, 0);
      end else if (v.esel) begin
         chk({tag, "_dtack_lat"}, r.dtk - r.ack, 1);
         chk({tag, "_sel_held"}, r.selend, 1);
      end
      chk({tag, "_both_low"}, r.both, 0);
      chk({tag, "_release"}, r.rel, 1);
   endtask

   // Spec-level prediction of one CPU cycle, starting from the previously latched card-side state.
   function automatic vec_t predict(input logic [31:0] a, input logic [15:0] d, input logic u, l, rw,
                                    input int ad, input logic [15:0] cd, input vec_t prev);
      vec_t e = prev;
      logic sh = (a[31:24] == 8'hF9);
      logic uh = (a[31:28] == 4'h9);
      e.addr = a; e.din = d; e.u = u; e.l = l; e.rw = rw; e.ad = ad; e.cd = cd;
      e.ehit = sh || uh;
      e.esel = e.ehit && (!u || !l);
      e.eberr = 1'b0;
      if (e.esel) begin
         e.ecaddr = (sh ? (a % 32'h0100_0000) : (a % 32'h1000_0000)) / 2 * 2;
         e.ecdout = d;
         e.eul = {!u, !l};
         e.erw = rw;
         e.eberr = (ad < 0);
         if (ad >= 0 && rw) e.edout = cd;
      end
      return e;
   endfunction

   vec_t vt[9];
   res_t r;
   vec_t st;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{32'hF9F0_0010, 16'h0000, 0, 0, 1, 4, 16'hA55A, 1, 1, 32'h00F0_0010, 16'h0000, 2'b11, 1, 0, 16'hA55A};
      vt[1] = '{32'hF908_0000, 16'h8000, 0, 1, 0, 2, 16'h1234, 1, 1, 32'h0008_0000, 16'h8000, 2'b10, 0, 0, 16'hA55A};
      vt[2] = '{32'h9123_4567, 16'h0000, 1, 0, 1, 0, 16'h0F0F, 1, 1, 32'h0123_4566, 16'h0000, 2'b01, 1, 0, 16'h0F0F};
      vt[3] = '{32'hF800_0000, 16'h5555, 0, 0, 1, 1, 16'h1111, 0, 0, 32'h0123_4566, 16'h0000, 2'b01, 1, 0, 16'h0F0F};
      vt[4] = '{32'hA000_0000, 16'h5555, 0, 0, 0, 1, 16'h1111, 0, 0, 32'h0123_4566, 16'h0000, 2'b01, 1, 0, 16'h0F0F};
      vt[5] = '{32'hF9FF_FFFF, 16'h7777, 1, 0, 0, 3, 16'h2222, 1, 1, 32'h00FF_FFFE, 16'h7777, 2'b01, 0, 0, 16'h0F0F};
      vt[6] = '{32'hF900_0100, 16'h0000, 0, 0, 1, -1, 16'h3333, 1, 1, 32'h0000_0100, 16'h0000, 2'b11, 1, 1, 16'h0F0F};
      vt[7] = '{32'hF900_0200, 16'h4444, 1, 1, 1, 1, 16'h4444, 1, 0, 32'h0000_0100, 16'h0000, 2'b11, 1, 0, 16'h0F0F};
      vt[8] = '{32'h9FFF_FFFE, 16'h0000, 0, 0, 1, 1, 16'hBEEF, 1, 1, 32'h0FFF_FFFE, 16'h0000, 2'b11, 1, 0, 16'hBEEF};

      reset = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1; cpu_rw_n = 1'b1; card_din = '0; card_ack_n = 1'b1; card_nmrq_n = 1'b0;
      repeat (3) tick();
      chk("rst_dtack", cpu_dtack_n, 1);  chk("rst_berr", cpu_berr_n, 1);
      chk("rst_select", card_select, 0); chk("rst_rw", card_rw_n, 1);
      chk("rst_ul", card_uds_lds, 0);    chk("rst_dout", cpu_dout, 0);
      chk("rst_caddr", card_addr, 0);    chk("rst_cdout", card_dout, 0);
      chk("rst_irq", slot_irq_n, 1);

      reset = 1'b0;
      tick(); chk("irq_assert_1clk", slot_irq_n, 1);
      tick(); chk("irq_assert_2clk", slot_irq_n, 0);
      card_nmrq_n = 1'b1;
      tick(); chk("irq_release_1clk", slot_irq_n, 0);
      tick(); chk("irq_release_2clk", slot_irq_n, 1);

      // Super slot address against a SUPER_EN=0 instance: no decode, no select.
      cpu_addr = 32'h9000_0000; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
      ackd = 1; cpu_as_n = 1'b0;
      #1 chk("nosuper_hit", slot_hit0, 0); chk("super_hit", slot_hit, 1);
      for (int k = 0; k < 3; k++) begin
         tick(); chk("nosuper_sel", card_select0, 0);
      end
      cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
      repeat (6) tick();

      for (int i = 0; i < 9; i++) begin
         run_cycle(vt[i].addr, vt[i].din, vt[i].u, vt[i].l, vt[i].rw, vt[i].ad, vt[i].cd, r);
         score($sformatf("vec%0d", i), vt[i], r);
      end

      // Abort: AS released in the same cycle the card acks.
      card_auto = 1'b0; card_ack_n = 1'b1;
      cpu_addr = 32'hF900_0020; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
      card_din = 16'h1111; cpu_as_n = 1'b0;
      tick(); chk("abort_sel_up", card_select, 1);
      tick();
      cpu_as_n = 1'b1; card_ack_n = 1'b0;
      tick(); chk("abort_sel_drop", card_select, 0); chk("abort_no_dtack", cpu_dtack_n, 1);
      cpu_addr = 32'hF900_0040; cpu_as_n = 1'b0; card_din = 16'h2222;
      for (int k = 0; k < 3; k++) begin
         tick(); chk("recover_wait_sel", card_select, 0); chk("recover_wait_dtack", cpu_dtack_n, 1);
      end
      card_ack_n = 1'b1;
      tick(); chk("recover_exit_sel", card_select, 0);
      tick(); chk("recover_next_sel", card_select, 1);
      card_ack_n = 1'b0;
      tick(); chk("manual_dtack", cpu_dtack_n, 0); chk("manual_dout", cpu_dout, 16'h2222);
      cpu_as_n = 1'b1;
      tick(); chk("manual_release", card_select, 0);
      card_ack_n = 1'b1; cpu_addr = 32'hF900_0060; cpu_as_n = 1'b0;
      tick(); chk("b2b_sel_1clk", card_select, 0);
      tick(); chk("b2b_sel_2clk", card_select, 0);
      tick(); chk("b2b_sel_3clk", card_select, 1);
      card_ack_n = 1'b0;
      tick(); chk("b2b_dtack", cpu_dtack_n, 0);
      cpu_as_n = 1'b1;
      tick(); card_ack_n = 1'b1;
      repeat (4) tick();
      card_auto = 1'b1; sel_prev = card_select;

      // Reset while waiting for an ack that never comes.
      cpu_addr = 32'hF900_0080; cpu_rw_n = 1'b1; ackd = -1; cpu_as_n = 1'b0;
      tick(); chk("rstmid_sel_up", card_select, 1);
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rstmid_sel", card_select, 0); chk("rstmid_dtack", cpu_dtack_n, 1);
      chk("rstmid_berr", cpu_berr_n, 1); chk("rstmid_caddr", card_addr, 0);
      chk("rstmid_dout", cpu_dout, 0);
      reset = 1'b0;
      tick(); chk("rstmid_idle_restart", card_select, 1);
      cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
      repeat (6) tick();

      // Random cycles scored against the spec-level model.
      st = '{32'h0, 16'h0, 1, 1, 1, 0, 16'h0, 0, 0, card_addr, card_dout, card_uds_lds, card_rw_n, 0, 16'h0000};
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         int ad;
         case ($urandom_range(0, 3))
            0: a = {8'hF9, 24'($urandom)};
            1: a = {4'h9, 28'($urandom)};
            2: a = $urandom;
            default: a = {4'hF, 4'($urandom_range(0, 15)), 24'($urandom)};
         endcase
         ad = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 6));
         st = predict(a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ad, 16'($urandom), st);
         run_cycle(st.addr, st.din, st.u, st.l, st.rw, st.ad, st.cd, r);
         score($sformatf("rnd%0d", i), st, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
